// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with 4-word lines.
// Hits return data combinationally; misses refill one line from a ready-handshake memory.
module icache_dm #(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic [31:0]  proc_addr,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic {IDLE, ALLOC} state_t;

  state_t               state_q, state_d;
  logic                 mem_read_q, mem_read_d;
  logic [27:0]          mem_addr_q, mem_addr_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [127:0]         data_arr [NUM_LINES];

  logic [IDX_W-1:0]     idx, fill_idx;
  logic [TAG_W-1:0]     tag, fill_tag;
  logic [1:0]           word;
  logic                 hit, install;
  logic                 unused_byte_off;

  assign idx             = proc_addr[IDX_W+3:4];
  assign tag             = proc_addr[31:IDX_W+4];
  assign word            = proc_addr[3:2];
  assign unused_byte_off = ^proc_addr[1:0];

  // Refill targets the latched miss address, not proc_addr, so the core may drop its request.
  assign fill_idx = mem_addr_q[IDX_W-1:0];
  assign fill_tag = mem_addr_q[27:IDX_W];

  assign hit        = proc_read & valid_q[idx] & (tag_arr[idx] == tag);
  assign proc_rdata = data_arr[idx][{word, 5'b0} +: 32];
  assign proc_stall = (state_q == ALLOC) | (proc_read & ~hit);
  assign install    = (state_q == ALLOC) & mem_ready & ~rst;
  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;

  always_comb begin
    state_d    = state_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (proc_read && !hit) begin
          mem_addr_d = proc_addr[31:4];
          mem_read_d = 1'b1;
          state_d    = ALLOC;
        end
      end
      ALLOC: begin
        if (mem_ready) begin
          valid_d[fill_idx] = 1'b1;
          mem_read_d        = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_rdata;
    end
  end

endmodule
